// File: rtl/spi_word_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module      : spi_word_sequencer                                         |
// | Description : Splits a wide word into MSB-first byte transfers for the   |
// |               byte-level SPI controller and reassembles the reply word.  |
// |               Optional per-byte watchdog: define SPI_SEQ_TIMEOUT_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_word_sequencer #(
  parameter int WORD_WIDTH     = 64,
  parameter int BYTE_WIDTH     = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid_in,
  output logic                  word_ready_out,
  output logic [BYTE_WIDTH-1:0] spi_data_out,
  output logic                  spi_trigger_out,
  input  logic [BYTE_WIDTH-1:0] spi_data_in,
  input  logic                  spi_valid_in,
  output logic [WORD_WIDTH-1:0] rx_word_out,
  output logic                  rx_valid_out,
  output logic                  busy_out,
  output logic                  error_out
);

  localparam int c_nbytes = WORD_WIDTH / BYTE_WIDTH;
  localparam int c_cnt_w  = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;
  localparam int c_gap_w  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(c_nbytes - 1);
  localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  logic [WORD_WIDTH-1:0]   r_tx_shift;
  logic [WORD_WIDTH-1:0]   r_rx_shift;
  logic [c_cnt_w-1:0]      r_byte_cnt;
  logic [c_gap_w-1:0]      r_gap_cnt;

  logic [WORD_WIDTH+BYTE_WIDTH-1:0] w_rx_cat;
  logic [WORD_WIDTH+BYTE_WIDTH-1:0] w_tx_cat;
  logic [WORD_WIDTH-1:0]            w_rx_next;
  logic [WORD_WIDTH-1:0]            w_tx_next;
  logic                             w_last;
  logic                             w_gap_done;
  logic                             w_timeout;

  // Concatenate-then-truncate keeps the shifts legal even when NBYTES == 1.
  assign w_rx_cat   = {r_rx_shift, spi_data_in};
  assign w_tx_cat   = {r_tx_shift, {BYTE_WIDTH{1'b0}}};
  assign w_rx_next  = w_rx_cat[WORD_WIDTH-1:0];
  assign w_tx_next  = w_tx_cat[WORD_WIDTH-1:0];
  assign w_last     = (r_byte_cnt == c_last_byte);
  assign w_gap_done = (r_gap_cnt == c_gap_last);

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int c_wd_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              r_error;

  // A reply arriving on the expiry cycle takes priority over the timeout.
  assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == c_wd_last) && !spi_valid_in;
  assign error_out = r_error;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wd_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error  <= w_timeout;
      r_wd_cnt <= (r_state == S_WAIT) ? r_wd_cnt + 1'b1 : '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state         <= S_IDLE;
      r_tx_shift      <= '0;
      r_rx_shift      <= '0;
      r_byte_cnt      <= '0;
      r_gap_cnt       <= '0;
      word_ready_out  <= 1'b1;
      spi_data_out    <= '0;
      spi_trigger_out <= 1'b0;
      rx_word_out     <= '0;
      rx_valid_out    <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      spi_trigger_out <= 1'b0;
      rx_valid_out    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (word_valid_in && word_ready_out) begin
            r_tx_shift      <= word_in;
            r_byte_cnt      <= '0;
            r_gap_cnt       <= '0;
            spi_data_out    <= word_in[WORD_WIDTH-1 -: BYTE_WIDTH];
            spi_trigger_out <= 1'b1;
            word_ready_out  <= 1'b0;
            busy_out        <= 1'b1;
            r_state         <= S_TRIG;
          end
        end
        S_TRIG: r_state <= S_WAIT;
        S_WAIT: begin
          if (spi_valid_in) begin
            r_rx_shift <= w_rx_next;
            r_tx_shift <= w_tx_next;
            if (w_last) begin
              rx_word_out  <= w_rx_next;
              rx_valid_out <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              if (GAP_CYCLES == 0) begin
                spi_data_out    <= w_tx_next[WORD_WIDTH-1 -: BYTE_WIDTH];
                spi_trigger_out <= 1'b1;
                r_state         <= S_TRIG;
              end else begin
                r_gap_cnt <= '0;
                r_state   <= S_GAP;
              end
            end
          end else if (w_timeout) begin
            word_ready_out <= 1'b1;
            busy_out       <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            spi_data_out    <= r_tx_shift[WORD_WIDTH-1 -: BYTE_WIDTH];
            spi_trigger_out <= 1'b1;
            r_state         <= S_TRIG;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        S_DONE: begin
          word_ready_out <= 1'b1;
          busy_out       <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          word_ready_out <= 1'b1;
          busy_out       <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_word_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_word_sequencer                                      |
// | Description : Self-checking bench with a behavioural SPI controller.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spi_word_sequencer;

  localparam int c_w  = 32;
  localparam int c_b  = 8;
  localparam int c_g  = 4;
  localparam int c_t  = 100;
  localparam int c_nb = c_w / c_b;

  logic           clk_in = 1'b0;
  logic           rst_n_in = 1'b0;
  logic [c_w-1:0] word_in = '0;
  logic           word_valid_in = 1'b0;
  logic           word_ready_out;
  logic [c_b-1:0] spi_data_out;
  logic           spi_trigger_out;
  logic [c_b-1:0] spi_data_in = '0;
  logic           spi_valid_in = 1'b0;
  logic [c_w-1:0] rx_word_out;
  logic           rx_valid_out;
  logic           busy_out;
  logic           error_out;

  spi_word_sequencer #(
    .WORD_WIDTH(c_w), .BYTE_WIDTH(c_b), .GAP_CYCLES(c_g), .TIMEOUT_CYCLES(c_t)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .word_in(word_in), .word_valid_in(word_valid_in), .word_ready_out(word_ready_out),
    .spi_data_out(spi_data_out), .spi_trigger_out(spi_trigger_out),
    .spi_data_in(spi_data_in), .spi_valid_in(spi_valid_in),
    .rx_word_out(rx_word_out), .rx_valid_out(rx_valid_out),
    .busy_out(busy_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Observation log, sampled mid-cycle.
  logic [c_b-1:0] trig_q[$];
  int             trig_cyc_q[$];
  logic [c_w-1:0] rx_q[$];
  int             rx_cyc_q[$];
  int             acc_cyc_q[$];
  int             err_cnt = 0;
  int             err_cyc = 0;
  bit             err_ready = 1'b0;
  int             vcnt = 0;

  always @(negedge clk_in) begin
    if (spi_trigger_out) begin
      trig_q.push_back(spi_data_out);
      trig_cyc_q.push_back(cyc);
    end
    if (rx_valid_out) begin
      rx_q.push_back(rx_word_out);
      rx_cyc_q.push_back(cyc);
    end
    if (word_valid_in && word_ready_out) acc_cyc_q.push_back(cyc);
    if (error_out) begin
      err_cnt++;
      err_cyc   = cyc;
      err_ready = word_ready_out;
    end
    if (spi_valid_in) vcnt++;
  end

  // Controller model: replies m_lat cycles after each trigger; mode 0 echo, 1 invert, 2 random.
  int             m_lat = 10;
  int             m_mode = 0;
  bit             m_on = 1'b1;
  bit             m_stray = 1'b0;
  logic [c_b-1:0] m_r;
  logic [c_b-1:0] resp_q[$];

  initial begin
    forever begin
      @(negedge clk_in);
      if (m_on && rst_n_in && spi_trigger_out) begin
        case (m_mode)
          0:       m_r = spi_data_out;
          1:       m_r = ~spi_data_out;
          default: m_r = 8'($urandom);
        endcase
        resp_q.push_back(m_r);
        repeat (m_lat) @(posedge clk_in);
        #1;
        spi_data_in  = m_r;
        spi_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        spi_valid_in = 1'b0;
        spi_data_in  = 8'($urandom);
        if (m_stray) begin
          @(posedge clk_in);
          #1;
          spi_data_in  = 8'h5A;
          spi_valid_in = 1'b1;
          @(posedge clk_in);
          #1;
          spi_valid_in = 1'b0;
        end
      end
    end
  end

  task automatic clear_obs();
    trig_q.delete();
    trig_cyc_q.delete();
    rx_q.delete();
    rx_cyc_q.delete();
    acc_cyc_q.delete();
    resp_q.delete();
  endtask

  task automatic send(input logic [c_w-1:0] w);
    bit ok;
    ok = 1'b0;
    word_in       = w;
    word_valid_in = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_in);
      if (word_ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_in);
    #1;
    word_valid_in = 1'b0;
    check("send_ready", 64'(ok), 64'd1);
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk_in);
      #2;
      if (rx_q.size() >= n) break;
    end
    check("rx_wait", 64'(rx_q.size() >= n), 64'd1);
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic do_word(input logic [c_w-1:0] w, input int lat, input int mode,
                         input bit stray, input string nm);
    logic [c_w-1:0] exp_rx;
    int             e0;
    clear_obs();
    e0      = err_cnt;
    m_lat   = lat;
    m_mode  = mode;
    m_stray = stray;
    send(w);
    wait_rx(1);
    m_stray = 1'b0;
    check({nm, "_ntrig"}, 64'(trig_q.size()), 64'(c_nb));
    for (int i = 0; i < c_nb; i++)
      if (i < trig_q.size())
        check($sformatf("%s_txbyte%0d", nm, i), 64'(trig_q[i]), 64'(w[c_w-1-c_b*i -: c_b]));
    exp_rx = '0;
    for (int i = 0; i < c_nb; i++) begin
      if (mode == 0)      exp_rx = w;
      else if (mode == 1) exp_rx = ~w;
      else if (i < resp_q.size()) exp_rx = {exp_rx[c_w-c_b-1:0], resp_q[i]};
    end
    check({nm, "_nrx"}, 64'(rx_q.size()), 64'd1);
    if (rx_q.size() > 0) check({nm, "_rxword"}, 64'(rx_q[0]), 64'(exp_rx));
    if (rx_cyc_q.size() > 0 && acc_cyc_q.size() > 0)
      check({nm, "_latency"}, 64'(rx_cyc_q[0] - acc_cyc_q[0]),
            64'(c_nb * (1 + lat) + (c_nb - 1) * c_g + 1));
    for (int i = 1; i < c_nb; i++)
      if (i < trig_cyc_q.size())
        check($sformatf("%s_spacing%0d", nm, i), 64'(trig_cyc_q[i] - trig_cyc_q[i-1]),
              64'(1 + lat + c_g));
    check({nm, "_noerr"}, 64'(err_cnt - e0), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    logic [c_w-1:0] pre;
    int             e0;

    repeat (3) @(posedge clk_in);
    #1;
    check("rst_ready", 64'(word_ready_out), 64'd1);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_trig", 64'(spi_trigger_out), 64'd0);
    check("rst_rxvalid", 64'(rx_valid_out), 64'd0);
    check("rst_rxword", 64'(rx_word_out), 64'd0);
    check("rst_data", 64'(spi_data_out), 64'd0);
    check("rst_err", 64'(error_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    do_word(32'hA1B2C3D4, 20, 0, 1'b0, "single");
    do_word(32'h0F1E2D3C, 10, 0, 1'b0, "gap");
    do_word(32'h55AA33CC, 10, 1, 1'b1, "stray_gap");

    // Stray valid while idle must not disturb anything.
    clear_obs();
    pre = rx_word_out;
    spi_data_in  = 8'h77;
    spi_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    spi_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("stray_idle_busy", 64'(busy_out), 64'd0);
    check("stray_idle_ready", 64'(word_ready_out), 64'd1);
    check("stray_idle_rxword", 64'(rx_word_out), 64'(pre));
    check("stray_idle_ntrig", 64'(trig_q.size()), 64'd0);

    // Back-to-back words with valid held high throughout.
    clear_obs();
    m_lat  = 3;
    m_mode = 1;
    word_in       = 32'h01020304;
    word_valid_in = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_in);
      if (word_ready_out) break;
    end
    @(posedge clk_in);
    #1;
    check("b2b_ready_drop0", 64'(word_ready_out), 64'd0);
    word_in = 32'hFFFFFFFF;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_in);
      if (word_ready_out) break;
    end
    @(posedge clk_in);
    #1;
    check("b2b_ready_drop1", 64'(word_ready_out), 64'd0);
    word_valid_in = 1'b0;
    wait_rx(2);
    check("b2b_naccept", 64'(acc_cyc_q.size()), 64'd2);
    check("b2b_ntrig", 64'(trig_q.size()), 64'd8);
    check("b2b_nrx", 64'(rx_q.size()), 64'd2);
    if (rx_q.size() > 1) begin
      check("b2b_rx0", 64'(rx_q[0]), 64'hFEFDFCFB);
      check("b2b_rx1", 64'(rx_q[1]), 64'h00000000);
    end
    if (trig_q.size() > 7) begin
      check("b2b_byte3", 64'(trig_q[3]), 64'h04);
      check("b2b_byte4", 64'(trig_q[4]), 64'hFF);
    end

    for (int n = 0; n < 6; n++)
      do_word(32'($urandom), $urandom_range(1, 12), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), $sformatf("rand%0d", n));

    // Reset after the second byte's reply.
    clear_obs();
    m_lat  = 6;
    m_mode = 0;
    vcnt   = 0;
    send(32'h13579BDF);
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk_in);
      #2;
      if (vcnt >= 2) break;
    end
    check("midrst_reached", 64'(vcnt >= 2), 64'd1);
    rst_n_in = 1'b0;
    #1;
    check("midrst_ready", 64'(word_ready_out), 64'd1);
    check("midrst_busy", 64'(busy_out), 64'd0);
    check("midrst_trig", 64'(spi_trigger_out), 64'd0);
    repeat (3) @(posedge clk_in);
    #1;
    check("midrst_nrx", 64'(rx_q.size()), 64'd0);
    check("midrst_rxword", 64'(rx_word_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    do_word(32'h2468ACE0, 5, 1, 1'b0, "after_rst");

`ifdef SPI_SEQ_TIMEOUT_EN
    clear_obs();
    m_on = 1'b0;
    e0   = err_cnt;
    send(32'hDEADBEEF);
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk_in);
      #2;
      if (err_cnt > e0) break;
    end
    repeat (5) @(posedge clk_in);
    #1;
    check("to_nerr", 64'(err_cnt - e0), 64'd1);
    if (trig_cyc_q.size() > 0)
      check("to_cycles", 64'(err_cyc - trig_cyc_q[0] - 1), 64'(c_t));
    check("to_ready", 64'(err_ready), 64'd1);
    check("to_nrx", 64'(rx_q.size()), 64'd0);
    check("to_ntrig", 64'(trig_q.size()), 64'd1);
    check("to_busy", 64'(busy_out), 64'd0);
    m_on = 1'b1;
    do_word(32'hC0FFEE11, 4, 0, 1'b0, "after_to");
`else
    e0 = 0;
    check("no_error_pulses", 64'(err_cnt), 64'(e0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_word_sequencer.md
Name: spi_word_sequencer

Overview:
Sits directly upstream of the byte-level SPI controller in comm_encryptor. Accepts one wide word (e.g. a ciphertext chunk) over a valid/ready handshake and splits it into BYTE_WIDTH-bit transfers, MSB byte first. For each byte it pulses the controller's trigger and waits for the controller's data-valid pulse. It assembles the bytes received back into a full-width response word.

Parameters:
WORD_WIDTH, 64, width of word accepted/returned; must be an integer multiple of BYTE_WIDTH
BYTE_WIDTH, 8, width of one SPI transaction; matches the controller's DATA_WIDTH
GAP_CYCLES, 4, idle clk_in cycles between a byte's valid pulse and the next trigger (CS deassert time); 0 allowed
TIMEOUT_CYCLES, 4096, watchdog limit per byte; used only with SPI_SEQ_TIMEOUT_EN

Ports:
clk_in  input  1  system clock (100 MHz)
rst_n_in  input  1  asynchronous active-low reset
word_in  input  WORD_WIDTH  word to transmit
word_valid_in  input  1  word_in is valid
word_ready_out  output  1  sequencer can accept a word
spi_data_out  output  BYTE_WIDTH  byte to controller data_in
spi_trigger_out  output  1  one-cycle start pulse to controller trigger_in
spi_data_in  input  BYTE_WIDTH  byte from controller data_out
spi_valid_in  input  1  controller data_valid_out
rx_word_out  output  WORD_WIDTH  assembled received word
rx_valid_out  output  1  one-cycle pulse; rx_word_out valid
busy_out  output  1  high from word accept until rx_valid_out cycle inclusive
error_out  output  1  one-cycle pulse on timeout (tied 0 without macro)

Behaviour:
- NBYTES = WORD_WIDTH/BYTE_WIDTH. Byte counter width is clog2(NBYTES), with a minimum of 1.
- Reset is asynchronous on the falling edge of rst_n_in.
  - All outputs go to 0 except word_ready_out, which is 1.
  - FSM goes to IDLE; shift registers and counters are cleared.
- States: IDLE, TRIG, WAIT, GAP, DONE.
- IDLE:
  - word_ready_out=1.
  - word_valid_in & word_ready_out in the same cycle is an accept.
  - On accept: latch word_in into tx_shift, clear byte_cnt, go to TRIG.
  - word_ready_out drops the cycle after the accept.
- TRIG:
  - spi_data_out = tx_shift[WORD_WIDTH-1 -: BYTE_WIDTH].
  - spi_trigger_out=1 for exactly this one cycle; go to WAIT.
  - spi_data_out holds stable from TRIG until the next TRIG.
- WAIT:
  - On spi_valid_in: rx_shift <= {rx_shift, spi_data_in} and tx_shift <<= BYTE_WIDTH.
  - If byte_cnt==NBYTES-1, go to DONE. Otherwise byte_cnt+1, then GAP (or TRIG directly if GAP_CYCLES==0).
  - spi_valid_in outside WAIT is ignored.
- GAP: count GAP_CYCLES cycles, then go to TRIG.
- DONE:
  - rx_word_out <= rx_shift, driven with the final byte included.
  - rx_valid_out=1 for one cycle; go to IDLE.
  - rx_word_out holds until the next DONE.
- Latency with an ideal controller responding in L cycles: accept to rx_valid_out = NBYTES*(1+L) + (NBYTES-1)*GAP_CYCLES + 1 cycles.
- Byte order: byte 0 sent = word_in[WORD_WIDTH-1 -: BYTE_WIDTH]. The first byte received lands in rx_word_out MSB.
- word_valid_in while busy has no effect. The upstream source must hold it until ready.
- spi_valid_in coincident with spi_trigger_out in TRIG is ignored; the controller cannot produce it.
- Reset mid-transfer: state is lost and no rx_valid_out is produced. The controller must be reset in the same domain.

Optional Feature:
SPI_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles in WAIT and clears on entering WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without spi_valid_in: pulse error_out for one cycle, go to IDLE, no rx_valid_out. Partial rx data is discarded.
  - spi_valid_in in the same cycle as the timeout wins; no error.
- Not defined: no watchdog logic; error_out is constant 0, and WAIT waits indefinitely.

Test Plan:
- Single word: WORD_WIDTH=32, word_in=0xA1B2C3D4, loopback model echoing each byte after 20 cycles -> spi_data_out sequence A1,B2,C3,D4; exactly 4 trigger pulses; rx_word_out=0xA1B2C3D4; one rx_valid_out.
- Gap timing: GAP_CYCLES=4, model valid 10 cycles after trigger -> trigger-to-trigger spacing is exactly 15 cycles; accept-to-rx_valid_out is 4*11+3*4+1=57 cycles.
- Back-to-back: word_valid_in held high with 0x01020304 then 0xFFFFFFFF; model returns inverted bytes -> ready drops after each accept; rx words are 0xFEFDFCFB then 0x00000000; no dropped triggers.
- Reset mid-word: assert rst_n_in low after the 2nd byte's valid -> immediate async clear; word_ready_out=1 and busy_out=0 the same cycle; no rx_valid_out; a new word after release completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=100): model never asserts valid -> error_out pulses exactly 100 cycles after entering WAIT; FSM returns to IDLE; no rx_valid_out.
- Stray valid: pulse spi_valid_in while in IDLE and GAP -> no state change; rx_word_out unchanged.
